abc_pkt_arb: RTL and testbench

Packet-granular round-robin arbiter that shares a single abc packet stream (sop/data/eop, 64-bit data) between NUM_REQ upstream requesters. It sits in front of the abc-port pipeline stage and drives its input port. A grant is held from the first beat to the last beat of a packet, so packets from different requesters never interleave. A beat-count limit truncates runaway packets.

---
 rtl/abc_pkt_arb.sv | 134 +++++++++++++
 tb/tb_abc_pkt_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/abc_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : abc_pkt_arb
// Brief    : Packet-granular round-robin arbiter onto a single abc stream.
// Revision : 1.0
// ============================================================================
module abc_pkt_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 256,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ-1:0]        in_sop,
  input  logic [NUM_REQ-1:0]        in_eop,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [DATA_W-1:0]         out_data,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      err_len,
  output logic                      err_frm
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2} state_t;

  state_t              r_state;
  logic [GW-1:0]       r_last_grant;
  logic [15:0]         r_beat_cnt;

  logic [NUM_REQ-1:0]  w_cand;
  logic [NUM_REQ-1:0]  w_stray;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [GW-1:0]       w_idx;
  logic [GW-1:0]       w_win;
  logic                w_found;
  logic                w_acc;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_gdata;
  logic [15:0]         w_cnt_inc;

  // Rotating search: first sop candidate strictly after the last winner.
  always_comb begin
    w_cand  = in_valid & in_sop;
    w_stray = in_valid & ~in_sop;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_win_oh   = NUM_REQ'(1) << w_win;
    w_grant_oh = NUM_REQ'(1) << grant_id;
    w_acc      = in_valid[grant_id];
    w_wdata    = in_data[w_win*DATA_W +: DATA_W];
    w_gdata    = in_data[grant_id*DATA_W +: DATA_W];
    w_cnt_inc  = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;
    if (r_state == IDLE)
      in_ready = w_stray | (w_found ? w_win_oh : '0);
    else
      in_ready = w_grant_oh;
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      grant_id     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_data     <= '0;
      err_len      <= 1'b0;
      err_frm      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      err_len   <= 1'b0;
      err_frm   <= 1'b0;
      case (r_state)
        IDLE: begin
          err_frm <= |w_stray;
          if (w_found) begin
            out_valid    <= 1'b1;
            out_sop      <= 1'b1;
            out_eop      <= in_eop[w_win];
            out_data     <= w_wdata;
            r_last_grant <= w_win;
            grant_id     <= w_win;
            r_beat_cnt   <= 16'd1;
            if (!in_eop[w_win])
              r_state <= XFER;
          end
        end
        XFER: begin
          if (w_acc) begin
            out_valid  <= 1'b1;
            out_data   <= w_gdata;
            r_beat_cnt <= w_cnt_inc;
            if (in_eop[grant_id]) begin
              out_eop <= 1'b1;
              r_state <= IDLE;
            end else if (w_cnt_inc == 16'(MAX_BEATS)) begin
              out_eop <= 1'b1;
              err_len <= 1'b1;
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_acc && in_eop[grant_id])
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_abc_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_abc_pkt_arb
// Brief    : Directed bench for abc_pkt_arb (default and MAX_BEATS=4 instances).
// Revision : 1.0
// ============================================================================
module tb_abc_pkt_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid = '0, in_sop = '0, in_eop = '0;
  logic [255:0] in_data = '0;

  logic [3:0]  rdy, rdy4;
  logic        ov, os, oe, bsy, el, ef;
  logic        ov4, os4, oe4, bsy4, el4, ef4;
  logic [63:0] od, od4;
  logic [1:0]  gid, gid4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  abc_pkt_arb #(.NUM_REQ(4), .DATA_W(64), .MAX_BEATS(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_ready(rdy), .out_valid(ov), .out_sop(os), .out_eop(oe),
    .out_data(od), .grant_id(gid), .busy(bsy), .err_len(el), .err_frm(ef));

  abc_pkt_arb #(.NUM_REQ(4), .DATA_W(64), .MAX_BEATS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_ready(rdy4), .out_valid(ov4), .out_sop(os4), .out_eop(oe4),
    .out_data(od4), .grant_id(gid4), .busy(bsy4), .err_len(el4), .err_frm(ef4));

  function automatic logic [63:0] dv(int i, int b);
    return 64'hD000_0000_0000_0000 | (64'(i) << 16) | 64'(b);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(int i, bit v, bit s, bit e, logic [63:0] d);
    in_valid[i] = v;
    in_sop[i]   = s;
    in_eop[i]   = e;
    in_data[i*64 +: 64] = d;
  endtask

  task automatic clr();
    in_valid = '0; in_sop = '0; in_eop = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check ready two time units after the inputs were applied.
  task automatic chk_rdy(string tag, logic [3:0] exp, bit use4);
    #2;
    chk({tag, ".ready"}, 64'(use4 ? rdy4 : rdy), 64'(exp));
  endtask

  task automatic chk_out(string tag, bit use4, bit v, bit s, bit e, logic [63:0] d, int g);
    chk({tag, ".valid"}, 64'(use4 ? ov4 : ov), 64'(v));
    if (v) begin
      chk({tag, ".sop"},  64'(use4 ? os4 : os), 64'(s));
      chk({tag, ".eop"},  64'(use4 ? oe4 : oe), 64'(e));
      chk({tag, ".data"}, use4 ? od4 : od, d);
    end
    chk({tag, ".grant"}, 64'(use4 ? gid4 : gid), 64'(g));
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    clr();
    tick();
    chk("rst.valid", 64'(ov), 64'd0);
    chk("rst.data", od, 64'd0);
    chk("rst.grant", 64'(gid), 64'd0);
    chk("rst.busy", 64'(bsy), 64'd0);
    chk("rst.errs", 64'({el, ef, el4, ef4}), 64'd0);
    rst_n = 1'b1;

    // Two simultaneous 3-beat packets: requester 0 then 2, no gap
    drv(0, 1, 1, 0, dv(0, 0)); drv(2, 1, 1, 0, dv(2, 0));
    chk_rdy("t1.c1", 4'b0001, 0);
    tick(); chk_out("t1.c1", 0, 1, 1, 0, dv(0, 0), 0);
    chk("t1.busy", 64'(bsy), 64'd1);
    drv(0, 1, 0, 0, dv(0, 1));
    chk_rdy("t1.c2", 4'b0001, 0);
    tick(); chk_out("t1.c2", 0, 1, 0, 0, dv(0, 1), 0);
    drv(0, 1, 0, 1, dv(0, 2));
    tick(); chk_out("t1.c3", 0, 1, 0, 1, dv(0, 2), 0);
    chk("t1.idle", 64'(bsy), 64'd0);
    drv(0, 0, 0, 0, '0);
    chk_rdy("t1.c4", 4'b0100, 0);
    tick(); chk_out("t1.c4", 0, 1, 1, 0, dv(2, 0), 2);
    drv(2, 1, 0, 0, dv(2, 1));
    tick(); chk_out("t1.c5", 0, 1, 0, 0, dv(2, 1), 2);
    drv(2, 1, 0, 1, dv(2, 2));
    tick(); chk_out("t1.c6", 0, 1, 0, 1, dv(2, 2), 2);
    clr();
    tick(); chk("t1.after", 64'(ov), 64'd0);

    // All four requesters streaming single-beat packets
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) drv(i, 1, 1, 1, dv(i, k));
      chk_rdy("t2", 4'(1 << (k % 4)), 0);
      tick();
      chk_out("t2", 0, 1, 1, 1, dv(k % 4, k), k % 4);
    end
    clr();

    // Requester 1 with a 2-cycle stall mid-packet; requester 0 waits for eop
    drv(1, 1, 1, 0, dv(1, 0));
    chk_rdy("t3.c1", 4'b0010, 0);
    tick(); chk_out("t3.c1", 0, 1, 1, 0, dv(1, 0), 1);
    drv(1, 1, 0, 0, dv(1, 1)); drv(0, 1, 1, 1, dv(0, 9));
    chk_rdy("t3.c2", 4'b0010, 0);
    tick(); chk_out("t3.c2", 0, 1, 0, 0, dv(1, 1), 1);
    drv(1, 0, 0, 0, '0);
    chk_rdy("t3.c3", 4'b0010, 0);
    tick(); chk_out("t3.c3", 0, 0, 0, 0, '0, 1);
    chk("t3.busy", 64'(bsy), 64'd1);
    tick(); chk_out("t3.c4", 0, 0, 0, 0, '0, 1);
    drv(1, 1, 0, 0, dv(1, 2));
    tick(); chk_out("t3.c5", 0, 1, 0, 0, dv(1, 2), 1);
    drv(1, 1, 1, 0, dv(1, 3));
    tick(); chk_out("t3.c6", 0, 1, 0, 0, dv(1, 3), 1);
    drv(1, 1, 0, 1, dv(1, 4));
    tick(); chk_out("t3.c7", 0, 1, 0, 1, dv(1, 4), 1);
    drv(1, 0, 0, 0, '0);
    chk_rdy("t3.c8", 4'b0001, 0);
    tick(); chk_out("t3.c8", 0, 1, 1, 1, dv(0, 9), 0);
    clr();

    // Truncation on the MAX_BEATS=4 instance; requester 3 sends 7 beats
    for (int b = 0; b < 7; b++) begin
      drv(3, 1, b == 0, b == 6, dv(3, b));
      if (b >= 4) chk_rdy("t4.drain", 4'b1000, 1);
      tick();
      chk_out("t4.d256", 0, 1, b == 0, b == 6, dv(3, b), 3);
      if (b < 4) chk_out("t4.d4", 1, 1, b == 0, b == 3, dv(3, b), 3);
      else       chk_out("t4.d4", 1, 0, 0, 0, '0, 3);
      chk("t4.err_len", 64'(el4), 64'(b == 3));
      chk("t4.err_len256", 64'(el), 64'd0);
      chk("t4.busy4", 64'(bsy4), 64'(b < 6));
    end
    drv(3, 0, 0, 0, '0);
    drv(0, 1, 1, 1, dv(0, 5)); drv(1, 1, 1, 1, dv(1, 5));
    chk_rdy("t4.next", 4'b0001, 1);
    tick(); chk_out("t4.next", 1, 1, 1, 1, dv(0, 5), 0);
    drv(0, 0, 0, 0, '0);
    tick(); chk_out("t4.next2", 1, 1, 1, 1, dv(1, 5), 1);
    clr();

    // Stray non-sop beats from requester 2 while idle
    drv(2, 1, 0, 0, dv(2, 7));
    chk_rdy("t5.c1", 4'b0100, 0);
    tick(); chk_out("t5.c1", 0, 0, 0, 0, '0, 1);
    chk("t5.c1.err_frm", 64'(ef), 64'd1);
    tick(); chk("t5.c2.err_frm", 64'(ef), 64'd1);
    chk("t5.c2.valid", 64'(ov), 64'd0);
    clr();
    tick(); chk("t5.c3.err_frm", 64'(ef), 64'd0);

    // Reset asserted during beat 2 of a 4-beat packet from requester 2
    drv(2, 1, 1, 0, dv(2, 0));
    tick(); chk_out("t6.c1", 0, 1, 1, 0, dv(2, 0), 2);
    drv(2, 1, 0, 0, dv(2, 1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.valid", 64'(ov), 64'd0);
    chk("t6.rst.grant", 64'(gid), 64'd0);
    chk("t6.rst.busy", 64'(bsy), 64'd0);
    chk("t6.rst.data", od, 64'd0);
    tick();
    rst_n = 1'b1;
    drv(0, 1, 1, 1, dv(0, 3)); drv(3, 1, 1, 1, dv(3, 3));
    chk_rdy("t6.r1", 4'b0101, 0);
    tick(); chk_out("t6.r1", 0, 1, 1, 1, dv(0, 3), 0);
    chk("t6.r1.err_frm", 64'(ef), 64'd1);
    drv(0, 0, 0, 0, '0); drv(2, 1, 0, 0, dv(2, 2));
    chk_rdy("t6.r2", 4'b1100, 0);
    tick(); chk_out("t6.r2", 0, 1, 1, 1, dv(3, 3), 3);
    chk("t6.r2.err_frm", 64'(ef), 64'd1);
    drv(3, 0, 0, 0, '0); drv(2, 1, 0, 1, dv(2, 3));
    tick(); chk_out("t6.r3", 0, 0, 0, 0, '0, 3);
    chk("t6.r3.err_frm", 64'(ef), 64'd1);
    clr();
    tick(); chk("t6.r4.err_frm", 64'(ef), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
